// File: rtl/eeprom_store_pkg.sv
// Shared constants and FSM state encoding for the EEPROM backing store.
// The state type is a plain vector with localparam encodings.
package eeprom_store_pkg;

   localparam int unsigned DefaultAddrWidth  = 15;
   localparam logic [7:0]  DefaultEraseValue = 8'hFF;

   typedef logic [2:0] state_t;

   localparam state_t StFill    = 3'd0;
   localparam state_t StIdle    = 3'd1;
   localparam state_t StEeAcc   = 3'd2;
   localparam state_t StEeDone  = 3'd3;
   localparam state_t StImgAcc  = 3'd4;
   localparam state_t StImgDone = 3'd5;

endpackage

// File: rtl/eeprom_backing_store_if.sv
// Bundles the EEPROM-side port, the host save-image port and the status flags.
// The store itself uses the slave modport; whoever drives the requests uses master.
interface eeprom_backing_store_if
   import eeprom_store_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefaultAddrWidth
);
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_read;
   logic                  ram_write;
   logic [7:0]            data_to_ram;
   logic [7:0]            data_from_ram;
   logic                  ram_done;

   logic [ADDR_WIDTH-1:0] img_addr;
   logic                  img_req;
   logic                  img_we;
   logic [7:0]            img_din;
   logic [7:0]            img_dout;
   logic                  img_ack;
   logic                  img_clr_dirty;

   logic                  ready;
   logic                  dirty;

   modport master (
      output ram_addr, ram_read, ram_write, data_to_ram,
      input  data_from_ram, ram_done,
      output img_addr, img_req, img_we, img_din, img_clr_dirty,
      input  img_dout, img_ack,
      input  ready, dirty
   );

   modport slave (
      input  ram_addr, ram_read, ram_write, data_to_ram,
      output data_from_ram, ram_done,
      input  img_addr, img_req, img_we, img_din, img_clr_dirty,
      output img_dout, img_ack,
      output ready, dirty
   );
endinterface

// File: rtl/eeprom_store_ram.sv
// Single-port synchronous RAM, one-cycle read latency, write-first on collisions.
module eeprom_store_ram #(
   parameter int unsigned ADDR_WIDTH = 15,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);
   localparam int unsigned Depth = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
         end else begin
            rdata     <= mem[addr];
         end
      end
   end
endmodule

// File: rtl/eeprom_backing_store.sv
// Byte-wide backing store shared by an emulated EEPROM and a host save-image port.
// After reset the whole array is filled with ERASE_VALUE before any request is served.
module eeprom_backing_store
   import eeprom_store_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = DefaultAddrWidth,
   parameter logic [7:0]  ERASE_VALUE = DefaultEraseValue
) (
   input logic                   clk,
   input logic                   reset_n,
   eeprom_backing_store_if.slave bus
);
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
   logic                  phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
   logic [7:0]            acc_data_q, acc_data_d;
   logic                  acc_we_q, acc_we_d;
   logic                  ready_q, ready_d;
   logic                  dirty_q, dirty_d;
   logic                  ram_done_q, ram_done_d;
   logic                  img_ack_q, img_ack_d;
   logic [7:0]            data_from_ram_q, data_from_ram_d;
   logic [7:0]            img_dout_q, img_dout_d;

   logic                  mem_en;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_wdata;
   logic [7:0]            mem_rdata;

   eeprom_store_ram #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (8)
   ) u_ram (
      .clk   (clk),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d         = state_q;
      fill_cnt_d      = fill_cnt_q;
      phase_d         = phase_q;
      acc_addr_d      = acc_addr_q;
      acc_data_d      = acc_data_q;
      acc_we_d        = acc_we_q;
      ready_d         = ready_q;
      dirty_d         = dirty_q;
      ram_done_d      = ram_done_q;
      img_ack_d       = img_ack_q;
      data_from_ram_d = data_from_ram_q;
      img_dout_d      = img_dout_q;
      mem_en          = 1'b0;
      mem_we          = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;

      // An EEPROM write commit below overrides a same-edge clear.
      if (bus.img_clr_dirty) begin
         dirty_d = 1'b0;
      end

      unique case (state_q)
         StFill: begin
            mem_en     = 1'b1;
            mem_we     = 1'b1;
            mem_addr   = fill_cnt_q;
            mem_wdata  = ERASE_VALUE;
            fill_cnt_d = fill_cnt_q + 1'b1;
            if (fill_cnt_q == '1) begin
               state_d = StIdle;
               ready_d = 1'b1;
            end
         end
         StIdle: begin
            if (bus.ram_read || bus.ram_write) begin
               state_d    = StEeAcc;
               phase_d    = 1'b0;
               acc_addr_d = bus.ram_addr;
               acc_data_d = bus.data_to_ram;
               acc_we_d   = bus.ram_write;
            end else if (bus.img_req) begin
               state_d    = StImgAcc;
               phase_d    = 1'b0;
               acc_addr_d = bus.img_addr;
               acc_data_d = bus.img_din;
               acc_we_d   = bus.img_we;
            end
         end
         StEeAcc: begin
            if (!phase_q) begin
               mem_en    = 1'b1;
               mem_we    = acc_we_q;
               mem_addr  = acc_addr_q;
               mem_wdata = acc_data_q;
               phase_d   = 1'b1;
               if (acc_we_q) begin
                  dirty_d = 1'b1;
               end
            end else begin
               state_d    = StEeDone;
               ram_done_d = 1'b1;
               if (!acc_we_q) begin
                  data_from_ram_d = mem_rdata;
               end
            end
         end
         StEeDone: begin
            if (!bus.ram_read && !bus.ram_write) begin
               state_d    = StIdle;
               ram_done_d = 1'b0;
            end
         end
         StImgAcc: begin
            if (!phase_q) begin
               mem_en    = 1'b1;
               mem_we    = acc_we_q;
               mem_addr  = acc_addr_q;
               mem_wdata = acc_data_q;
               phase_d   = 1'b1;
            end else begin
               state_d   = StImgDone;
               img_ack_d = 1'b1;
               if (!acc_we_q) begin
                  img_dout_d = mem_rdata;
               end
            end
         end
         StImgDone: begin
            if (!bus.img_req) begin
               state_d   = StIdle;
               img_ack_d = 1'b0;
            end
         end
         default: begin
            state_d = StFill;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= StFill;
         fill_cnt_q      <= '0;
         phase_q         <= 1'b0;
         acc_addr_q      <= '0;
         acc_data_q      <= '0;
         acc_we_q        <= 1'b0;
         ready_q         <= 1'b0;
         dirty_q         <= 1'b0;
         ram_done_q      <= 1'b0;
         img_ack_q       <= 1'b0;
         data_from_ram_q <= 8'h00;
         img_dout_q      <= 8'h00;
      end else begin
         state_q         <= state_d;
         fill_cnt_q      <= fill_cnt_d;
         phase_q         <= phase_d;
         acc_addr_q      <= acc_addr_d;
         acc_data_q      <= acc_data_d;
         acc_we_q        <= acc_we_d;
         ready_q         <= ready_d;
         dirty_q         <= dirty_d;
         ram_done_q      <= ram_done_d;
         img_ack_q       <= img_ack_d;
         data_from_ram_q <= data_from_ram_d;
         img_dout_q      <= img_dout_d;
      end
   end

   assign bus.ready         = ready_q;
   assign bus.dirty         = dirty_q;
   assign bus.ram_done      = ram_done_q;
   assign bus.img_ack       = img_ack_q;
   assign bus.data_from_ram = data_from_ram_q;
   assign bus.img_dout      = img_dout_q;
endmodule

// File: tb/tb_eeprom_backing_store.sv
// Directed bench for eeprom_backing_store: fill, EEPROM and host accesses,
// arbitration, dirty tracking, held handshakes and reset during an access.
module tb_eeprom_backing_store;
   localparam int unsigned AW = 15;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_checks = 0;
   int   n_fails = 0;

   always #5 clk = ~clk;

   eeprom_backing_store_if #(.ADDR_WIDTH(AW)) bus ();

   eeprom_backing_store #(
      .ADDR_WIDTH  (AW),
      .ERASE_VALUE (8'hFF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until ready rises; -1 when the bound expires.
   task automatic wait_ready(output int n);
      n = -1;
      for (int i = 1; i <= 40000; i++) begin
         tick();
         if (bus.ready) begin
            n = i;
            break;
         end
      end
   endtask

   // Full EEPROM handshake; lat counts edges from request to ram_done (-1 on timeout).
   task automatic ee_access(input logic rd, input logic wr, input logic [AW-1:0] addr,
                            input logic [7:0] din, output int lat, output logic [7:0] q);
      bus.ram_addr    = addr;
      bus.data_to_ram = din;
      bus.ram_read    = rd;
      bus.ram_write   = wr;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.ram_done) begin
            lat = i;
            break;
         end
      end
      q = bus.data_from_ram;
      bus.ram_read  = 1'b0;
      bus.ram_write = 1'b0;
      tick();
   endtask

   task automatic img_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] din,
                             output int lat, output logic [7:0] q);
      bus.img_addr = addr;
      bus.img_din  = din;
      bus.img_we   = we;
      bus.img_req  = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.img_ack) begin
            lat = i;
            break;
         end
      end
      q = bus.img_dout;
      bus.img_req = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      n_checks += 6;
      if (bus.ready !== 1'b0) begin
         n_fails++; $display("FAIL reset_ready: got %b, expected 0", bus.ready);
      end
      if (bus.dirty !== 1'b0) begin
         n_fails++; $display("FAIL reset_dirty: got %b, expected 0", bus.dirty);
      end
      if (bus.ram_done !== 1'b0) begin
         n_fails++; $display("FAIL reset_ram_done: got %b, expected 0", bus.ram_done);
      end
      if (bus.img_ack !== 1'b0) begin
         n_fails++; $display("FAIL reset_img_ack: got %b, expected 0", bus.img_ack);
      end
      if (bus.data_from_ram !== 8'h00) begin
         n_fails++; $display("FAIL reset_data_from_ram: got %h, expected 00", bus.data_from_ram);
      end
      if (bus.img_dout !== 8'h00) begin
         n_fails++; $display("FAIL reset_img_dout: got %h, expected 00", bus.img_dout);
      end
   endtask

   // Host read of the top address is left pending across the whole fill.
   task automatic test_fill();
      int   n;
      int   lat;
      logic saw_ack;
      bus.img_addr = 15'h7FFF;
      bus.img_we   = 1'b0;
      bus.img_req  = 1'b1;
      reset_n      = 1'b1;
      saw_ack      = 1'b0;
      n = -1;
      for (int i = 1; i <= 40000; i++) begin
         tick();
         if (bus.img_ack) saw_ack = 1'b1;
         if (bus.ready) begin
            n = i;
            break;
         end
      end
      n_checks += 2;
      if (n !== 32768) begin
         n_fails++; $display("FAIL fill_ready_latency: got %0d, expected 32768", n);
      end
      if (saw_ack !== 1'b0) begin
         n_fails++; $display("FAIL fill_req_ignored: got ack %b during fill, expected 0", saw_ack);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.img_ack) begin
            lat = i;
            break;
         end
      end
      n_checks += 2;
      if (lat !== 3) begin
         n_fails++; $display("FAIL fill_pending_img_latency: got %0d, expected 3", lat);
      end
      if (bus.img_dout !== 8'hFF) begin
         n_fails++; $display("FAIL fill_read_7fff: got %h, expected ff", bus.img_dout);
      end
      bus.img_req = 1'b0;
      tick();
      n_checks++;
      if (bus.img_ack !== 1'b0) begin
         n_fails++; $display("FAIL fill_img_ack_release: got %b, expected 0", bus.img_ack);
      end
   endtask

   task automatic test_ee_write_read();
      int         lat;
      logic [7:0] q;
      ee_access(1'b0, 1'b1, 15'h0123, 8'hA5, lat, q);
      n_checks += 4;
      if (lat !== 3) begin
         n_fails++; $display("FAIL ee_write_latency: got %0d, expected 3", lat);
      end
      if (bus.dirty !== 1'b1) begin
         n_fails++; $display("FAIL ee_write_dirty: got %b, expected 1", bus.dirty);
      end
      if (bus.ram_done !== 1'b0) begin
         n_fails++; $display("FAIL ee_write_done_release: got %b, expected 0", bus.ram_done);
      end
      if (bus.data_from_ram !== 8'h00) begin
         n_fails++; $display("FAIL ee_write_keeps_rdata: got %h, expected 00", bus.data_from_ram);
      end
      ee_access(1'b1, 1'b0, 15'h0123, 8'h00, lat, q);
      n_checks += 3;
      if (lat !== 3) begin
         n_fails++; $display("FAIL ee_read_latency: got %0d, expected 3", lat);
      end
      if (q !== 8'hA5) begin
         n_fails++; $display("FAIL ee_read_0123: got %h, expected a5", q);
      end
      if (bus.dirty !== 1'b1) begin
         n_fails++; $display("FAIL ee_read_dirty: got %b, expected 1", bus.dirty);
      end
      // Read and write together must behave as a write.
      ee_access(1'b1, 1'b1, 15'h0200, 8'h5A, lat, q);
      ee_access(1'b1, 1'b0, 15'h0200, 8'h00, lat, q);
      n_checks++;
      if (q !== 8'h5A) begin
         n_fails++; $display("FAIL ee_rw_is_write: got %h, expected 5a", q);
      end
   endtask

   task automatic test_collision();
      int lat;
      bus.ram_addr = 15'h0123;
      bus.ram_read = 1'b1;
      bus.img_addr = 15'h7FFF;
      bus.img_we   = 1'b0;
      bus.img_req  = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.ram_done || bus.img_ack) begin
            lat = i;
            break;
         end
      end
      n_checks += 3;
      if (lat !== 3 || bus.ram_done !== 1'b1) begin
         n_fails++; $display("FAIL coll_ee_first: got lat %0d done %b, expected 3 and 1",
                             lat, bus.ram_done);
      end
      if (bus.img_ack !== 1'b0) begin
         n_fails++; $display("FAIL coll_img_waits: got %b, expected 0", bus.img_ack);
      end
      if (bus.data_from_ram !== 8'hA5) begin
         n_fails++; $display("FAIL coll_ee_data: got %h, expected a5", bus.data_from_ram);
      end
      bus.ram_read = 1'b0;
      tick();
      n_checks++;
      if (bus.ram_done !== 1'b0 || bus.img_ack !== 1'b0) begin
         n_fails++; $display("FAIL coll_done_falls: got done %b ack %b, expected 0 0",
                             bus.ram_done, bus.img_ack);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.img_ack) begin
            lat = i;
            break;
         end
      end
      n_checks += 2;
      if (lat !== 3) begin
         n_fails++; $display("FAIL coll_img_latency: got %0d, expected 3", lat);
      end
      if (bus.img_dout !== 8'hFF) begin
         n_fails++; $display("FAIL coll_img_data: got %h, expected ff", bus.img_dout);
      end
      bus.img_req = 1'b0;
      tick();
   endtask

   task automatic test_dirty();
      int         lat;
      logic [7:0] q;
      bus.img_clr_dirty = 1'b1;
      tick();
      bus.img_clr_dirty = 1'b0;
      n_checks++;
      if (bus.dirty !== 1'b0) begin
         n_fails++; $display("FAIL dirty_lone_clear: got %b, expected 0", bus.dirty);
      end
      // Clear pulse lands on the commit edge (acceptance + 1).
      bus.ram_addr    = 15'h0300;
      bus.data_to_ram = 8'h11;
      bus.ram_write   = 1'b1;
      tick();
      bus.img_clr_dirty = 1'b1;
      tick();
      bus.img_clr_dirty = 1'b0;
      n_checks++;
      if (bus.dirty !== 1'b1) begin
         n_fails++; $display("FAIL dirty_clear_vs_commit: got %b, expected 1", bus.dirty);
      end
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         if (bus.ram_done) begin
            lat = i;
            break;
         end
         tick();
      end
      bus.ram_write = 1'b0;
      tick();
      n_checks++;
      if (lat < 0 || bus.ram_done !== 1'b0) begin
         n_fails++; $display("FAIL dirty_write_handshake: got lat %0d done %b, expected done 0",
                             lat, bus.ram_done);
      end
      bus.img_clr_dirty = 1'b1;
      tick();
      bus.img_clr_dirty = 1'b0;
      img_access(1'b1, 15'h0010, 8'h3C, lat, q);
      n_checks += 2;
      if (lat !== 3) begin
         n_fails++; $display("FAIL img_write_latency: got %0d, expected 3", lat);
      end
      if (bus.dirty !== 1'b0) begin
         n_fails++; $display("FAIL dirty_host_write: got %b, expected 0", bus.dirty);
      end
      img_access(1'b0, 15'h0010, 8'h00, lat, q);
      n_checks++;
      if (q !== 8'h3C) begin
         n_fails++; $display("FAIL img_read_0010: got %h, expected 3c", q);
      end
   endtask

   task automatic test_held();
      int lat;
      int bad;
      bus.ram_addr = 15'h0200;
      bus.ram_read = 1'b1;
      lat = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (bus.ram_done) begin
            lat = i;
            break;
         end
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.ram_done !== 1'b1 || bus.data_from_ram !== 8'h5A) bad++;
      end
      n_checks += 2;
      if (lat !== 3) begin
         n_fails++; $display("FAIL held_latency: got %0d, expected 3", lat);
      end
      if (bad !== 0) begin
         n_fails++; $display("FAIL held_stable: got %0d bad cycles, expected 0", bad);
      end
      bus.ram_read = 1'b0;
      tick();
      n_checks += 2;
      if (bus.ram_done !== 1'b0) begin
         n_fails++; $display("FAIL held_release: got %b, expected 0", bus.ram_done);
      end
      if (bus.data_from_ram !== 8'h5A) begin
         n_fails++; $display("FAIL held_data_kept: got %h, expected 5a", bus.data_from_ram);
      end
   endtask

   task automatic test_reset_mid_write();
      int         n;
      int         lat;
      logic [7:0] q;
      bus.ram_addr    = 15'h0123;
      bus.data_to_ram = 8'h77;
      bus.ram_write   = 1'b1;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      n_checks += 3;
      if (bus.ram_done !== 1'b0) begin
         n_fails++; $display("FAIL rst_mid_done: got %b, expected 0", bus.ram_done);
      end
      if (bus.ready !== 1'b0) begin
         n_fails++; $display("FAIL rst_mid_ready: got %b, expected 0", bus.ready);
      end
      if (bus.dirty !== 1'b0) begin
         n_fails++; $display("FAIL rst_mid_dirty: got %b, expected 0", bus.dirty);
      end
      bus.ram_write = 1'b0;
      tick();
      reset_n = 1'b1;
      wait_ready(n);
      n_checks++;
      if (n !== 32768) begin
         n_fails++; $display("FAIL rst_refill_latency: got %0d, expected 32768", n);
      end
      ee_access(1'b1, 1'b0, 15'h0123, 8'h00, lat, q);
      n_checks += 2;
      if (q !== 8'hFF) begin
         n_fails++; $display("FAIL rst_read_0123: got %h, expected ff", q);
      end
      if (bus.dirty !== 1'b0) begin
         n_fails++; $display("FAIL rst_dirty_after_read: got %b, expected 0", bus.dirty);
      end
   endtask

   initial begin
      bus.ram_addr      = '0;
      bus.ram_read      = 1'b0;
      bus.ram_write     = 1'b0;
      bus.data_to_ram   = 8'h00;
      bus.img_addr      = '0;
      bus.img_req       = 1'b0;
      bus.img_we        = 1'b0;
      bus.img_din       = 8'h00;
      bus.img_clr_dirty = 1'b0;
      reset_n           = 1'b0;
      tick();
      tick();
      tick();
      test_reset();
      test_fill();
      test_ee_write_read();
      test_collision();
      test_dirty();
      test_held();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
